mem_access_sequencer: RTL

- MEM-stage controller for the pipelined LC-3b; sits between the EX/MEM latch control fields and the data-memory (D-cache) port.
- Sequences single-word, byte (LDB/STB) and two-step indirect (LDI/STI) accesses.
- Holds the pipeline with `stall` until the access completes, then presents the load result to MEM/WB.

---
 rtl/mem_access_sequencer_if.sv | 33 +++
 rtl/mem_access_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: pipeline control fields and data-memory bus of the MEM-stage sequencer
interface mem_access_sequencer_if;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic        mem_indirect;
    logic        byte_access;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] rdata_out;
    logic        stall;
    logic        done;
    logic        err;
    modport master (
        output start, mem_read, mem_write, mem_indirect, byte_access, addr_in, wdata_in,
        output dmem_rdata, dmem_resp,
        input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        input  rdata_out, stall, done, err
    );
    modport slave (
        input  start, mem_read, mem_write, mem_indirect, byte_access, addr_in, wdata_in,
        input  dmem_rdata, dmem_resp,
        output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        output rdata_out, stall, done, err
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: LC-3b MEM-stage D-cache sequencer for word, byte and indirect accesses.
// Define MEM_SEQ_TIMEOUT_EN to abort an access after TIMEOUT cycles without dmem_resp.
module mem_access_sequencer #(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    mem_access_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, PTR = 2'd1, ACC = 2'd2, DONE = 2'd3;
    logic [1:0] state;
    logic       wr;
    logic       bsel;
    logic       lsb;
    logic       access;
    logic       strobe;
    logic       hit;
    logic       expire;
    logic [7:0] byte_val;
    assign access   = bus.start & (bus.mem_read | bus.mem_write);
    assign strobe   = bus.dmem_read | bus.dmem_write;
    assign hit      = strobe & bus.dmem_resp;
    assign byte_val = lsb ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0];
    assign bus.stall = rst_n & ((state == IDLE & access) | state == PTR | state == ACC);
    assign bus.done  = state == DONE;
`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign expire  = strobe & ~bus.dmem_resp & (cnt == CW'(TIMEOUT - 1));
    assign bus.err = err_q;
    // strobes are only ever high in PTR/ACC, so counting strobe cycles is the wait time
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= strobe & ~expire ? cnt + 1'b1 : '0;
            err_q <= expire;
        end
`else
    assign expire  = 1'b0;
    assign bus.err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state                <= IDLE;
            wr                   <= 1'b0;
            bsel                 <= 1'b0;
            lsb                  <= 1'b0;
            bus.dmem_address     <= '0;
            bus.dmem_read        <= 1'b0;
            bus.dmem_write       <= 1'b0;
            bus.dmem_byte_enable <= '0;
            bus.dmem_wdata       <= '0;
            bus.rdata_out        <= '0;
        end else begin
            case (state)
                IDLE: if (access) begin
                    wr                   <= ~bus.mem_read;
                    bsel                 <= bus.byte_access & ~bus.mem_indirect;
                    lsb                  <= bus.addr_in[0];
                    bus.dmem_address     <= {bus.addr_in[15:1], 1'b0};
                    bus.dmem_wdata       <= bus.byte_access & ~bus.mem_indirect ? {2{bus.wdata_in[7:0]}} : bus.wdata_in;
                    bus.dmem_byte_enable <= bus.mem_read ? 2'b00 :
                                            ~(bus.byte_access & ~bus.mem_indirect) ? 2'b11 :
                                            bus.addr_in[0] ? 2'b10 : 2'b01;
                    bus.dmem_read        <= bus.mem_read | bus.mem_indirect;
                    bus.dmem_write       <= ~bus.mem_read & ~bus.mem_indirect;
                    state                <= bus.mem_indirect ? PTR : ACC;
                end
                PTR: if (expire) begin
                    bus.dmem_read <= 1'b0;
                    bus.rdata_out <= '0;
                    state         <= DONE;
                end else if (hit) begin
                    bus.dmem_read    <= 1'b0;
                    bus.dmem_address <= {bus.dmem_rdata[15:1], 1'b0};
                    state            <= ACC;
                end
                // ACC entered from PTR starts with the strobe low for the mandated one-cycle gap
                ACC: if (expire) begin
                    bus.dmem_read  <= 1'b0;
                    bus.dmem_write <= 1'b0;
                    bus.rdata_out  <= '0;
                    state          <= DONE;
                end else if (!strobe) begin
                    bus.dmem_read  <= ~wr;
                    bus.dmem_write <= wr;
                end else if (hit) begin
                    bus.dmem_read  <= 1'b0;
                    bus.dmem_write <= 1'b0;
                    if (!wr)
                        bus.rdata_out <= bsel ? {{8{byte_val[7]}}, byte_val} : bus.dmem_rdata;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
